// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master drives the request and flush; the slave reports busy, completion and result.
interface muldiv_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            enabled;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            busy;
   logic            completed;
   logic [XLEN-1:0] result;

   modport master (
      output enabled, op, rs1, rs2, flush,
      input  busy, completed, result
   );

   modport slave (
      input  enabled, op, rs1, rs2, flush,
      output busy, completed, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: fixed-latency multiplier and
// restoring radix-2 divider, with divide-by-zero/overflow resolved at accept.
module muldiv_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MUL_LATENCY = 2
) (
   input  logic     clk,
   input  logic     rstn,
   muldiv_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t          state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]      op_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            neg_q, neg_r, is_rem;
   logic            pend;
   logic [XLEN-1:0] spec_q;
   logic            busy_q, completed_q;
   logic [XLEN-1:0] result_q;

   assign bus.busy      = busy_q;
   assign bus.completed = completed_q;
   assign bus.result    = result_q;

   // Request decode; the special-case result is known at accept time.
   logic            sgn_div, rs1_neg, rs2_neg, div_zero, div_ovf;
   logic [XLEN-1:0] rs1_mag, rs2_mag, spec_res;

   always_comb begin
      sgn_div  = ~bus.op[0];
      rs1_neg  = sgn_div & bus.rs1[XLEN-1];
      rs2_neg  = sgn_div & bus.rs2[XLEN-1];
      rs1_mag  = rs1_neg ? -bus.rs1 : bus.rs1;
      rs2_mag  = rs2_neg ? -bus.rs2 : bus.rs2;
      div_zero = (bus.rs2 == '0);
      div_ovf  = sgn_div && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
      if (div_zero)
         spec_res = bus.op[1] ? bus.rs1 : '1;
      else
         spec_res = bus.op[1] ? '0 : bus.rs1;
   end

   // Operands are extended to 2*XLEN so a plain modular product is exact.
   logic              mul_a_sgn, mul_b_sgn;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      mul_a_sgn = (op_q[1:0] != 2'b11);
      mul_b_sgn = ~op_q[1];
      mul_a     = {{XLEN{mul_a_sgn & rs1_q[XLEN-1]}}, rs1_q};
      mul_b     = {{XLEN{mul_b_sgn & rs2_q[XLEN-1]}}, rs2_q};
      prod      = mul_a * mul_b;
      mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   logic [XLEN:0]   shifted, diff;
   logic [XLEN-1:0] quo_fix, rem_fix;

   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      quo_fix = neg_q ? -quo_q : quo_q;
      rem_fix = neg_r ? -rem_q : rem_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         is_rem      <= 1'b0;
         pend        <= 1'b0;
         spec_q      <= '0;
         busy_q      <= 1'b0;
         completed_q <= 1'b0;
         result_q    <= '0;
      end else if (bus.flush) begin
         state       <= S_IDLE;
         pend        <= 1'b0;
         busy_q      <= 1'b0;
         completed_q <= 1'b0;
      end else begin
         completed_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pend) begin
                  pend        <= 1'b0;
                  result_q    <= spec_q;
                  completed_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (bus.enabled) begin
                  busy_q <= 1'b1;
                  op_q   <= bus.op;
                  rs1_q  <= bus.rs1;
                  rs2_q  <= bus.rs2;
                  cnt    <= CNT_W'(1);
                  if (!bus.op[2]) begin
                     state <= S_MUL;
                  end else if (div_zero || div_ovf) begin
                     pend   <= 1'b1;
                     spec_q <= spec_res;
                  end else begin
                     state  <= S_DIV;
                     cnt    <= '0;
                     rem_q  <= '0;
                     quo_q  <= rs1_mag;
                     dvs_q  <= rs2_mag;
                     neg_q  <= rs1_neg ^ rs2_neg;
                     neg_r  <= rs1_neg;
                     is_rem <= bus.op[1];
                  end
               end
            end
            S_MUL: begin
               if (cnt == CNT_W'(MUL_LATENCY)) begin
                  result_q    <= mul_res;
                  completed_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DIV: begin
               if (!diff[XLEN]) begin
                  rem_q <= diff[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
            end
            S_FIX: begin
               result_q    <= is_rem ? rem_fix : quo_fix;
               completed_q <= 1'b1;
               busy_q      <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32/MUL_LATENCY=2 and XLEN=64/MUL_LATENCY=4.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rstn32, rstn64;
   int unsigned cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_if #(.XLEN(32)) bus32 ();
   muldiv_if #(.XLEN(64)) bus64 ();

   muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) u32 (.clk(clk), .rstn(rstn32), .bus(bus32));
   muldiv_unit #(.XLEN(64), .MUL_LATENCY(4)) u64 (.clk(clk), .rstn(rstn64), .bus(bus64));

   logic [63:0] q_res [2][$];
   int unsigned q_due [2][$];
   string       q_nm  [2][$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic [63:0] res);
      logic [63:0] e;
      int unsigned due;
      string nm;
      if (q_res[d].size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_completion dut=%0d actual=%h expected=none", d, res);
      end else begin
         e   = q_res[d].pop_front();
         due = q_due[d].pop_front();
         nm  = q_nm[d].pop_front();
         chk(nm, res, e);
         chk({nm, "_latency"}, 64'(cyc), 64'(due));
      end
   endtask

   always @(negedge clk) if (bus32.completed === 1'b1) mon(0, {32'h0, bus32.result});
   always @(negedge clk) if (bus64.completed === 1'b1) mon(1, bus64.result);

   task automatic drive(input int d, input logic en, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (d == 0) begin
         bus32.enabled = en; bus32.op = op; bus32.rs1 = a[31:0]; bus32.rs2 = b[31:0];
      end else begin
         bus64.enabled = en; bus64.op = op; bus64.rs1 = a; bus64.rs2 = b;
      end
   endtask

   function automatic logic get_busy(input int d);
      return (d == 0) ? bus32.busy : bus64.busy;
   endfunction

   // Called at a negedge; the request is accepted on the following posedge.
   task automatic issue(input int d, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp,
                        input int unsigned lat, input string nm);
      drive(d, 1'b1, op, a, b);
      q_res[d].push_back(exp);
      q_due[d].push_back(cyc + 1 + lat);
      q_nm[d].push_back(nm);
      @(negedge clk);
      drive(d, 1'b0, 3'd0, 64'd0, 64'd0);
      chk({nm, "_busy"}, {63'd0, get_busy(d)}, 64'd1);
   endtask

   task automatic wait_done(input int d, input int budget);
      int n = 0;
      while (q_res[d].size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (q_res[d].size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout dut=%0d actual=pending expected=completed", d);
         q_res[d].delete(); q_due[d].delete(); q_nm[d].delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input int d, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp,
                      input int unsigned lat, input string nm);
      issue(d, op, a, b, exp, lat, nm);
      wait_done(d, 100);
   endtask

   initial begin
      rstn32 = 1'b0; rstn64 = 1'b0;
      bus32.flush = 1'b0; bus64.flush = 1'b0;
      drive(0, 1'b0, 3'd0, 64'd0, 64'd0);
      drive(1, 1'b0, 3'd0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst32_busy", {63'd0, bus32.busy}, 64'd0);
      chk("rst32_completed", {63'd0, bus32.completed}, 64'd0);
      chk("rst32_result", {32'd0, bus32.result}, 64'd0);
      chk("rst64_busy", {63'd0, bus64.busy}, 64'd0);
      chk("rst64_result", bus64.result, 64'd0);
      rstn32 = 1'b1; rstn64 = 1'b1;
      @(negedge clk);

      run(0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 2, "mulh");
      run(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2, "mulhu");
      run(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2, "mulhsu");
      run(0, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 2, "mul");
      run(0, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33, "div_m7_2");
      run(0, 3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33, "rem_m7_2");
      run(0, 3'd5, 64'hFFFFFFF9, 64'd2, 64'h7FFFFFFC, 33, "divu_m7_2");
      run(0, 3'd7, 64'hFFFFFFF9, 64'd2, 64'h00000001, 33, "remu_m7_2");
      run(0, 3'd4, 64'h80000000, 64'd2, 64'hC0000000, 33, "div_minneg_2");
      run(0, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1, "divu_by0");
      run(0, 3'd7, 64'd5, 64'd0, 64'h00000005, 1, "remu_by0");
      run(0, 3'd6, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFB, 1, "rem_by0");
      run(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, "div_ovf");
      run(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1, "rem_ovf");

      // Requests arriving while busy must be dropped.
      issue(0, 3'd4, 64'd100, 64'd7, 64'd14, 33, "div_ignore");
      for (int k = 1; k <= 25; k++) begin
         if (k >= 5 && k <= 20) drive(0, k[0], 3'd0, 64'd3, 64'd4);
         else drive(0, 1'b0, 3'd0, 64'd0, 64'd0);
         chk("ignore_busy", {63'd0, bus32.busy}, 64'd1);
         @(negedge clk);
      end
      wait_done(0, 100);
      repeat (5) @(negedge clk);

      // Flush mid-divide: no completion, result retains 14.
      drive(0, 1'b1, 3'd4, 64'd1000, 64'd3);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 64'd0, 64'd0);
      repeat (9) @(negedge clk);
      bus32.flush = 1'b1;
      @(negedge clk);
      bus32.flush = 1'b0;
      chk("flush_busy", {63'd0, bus32.busy}, 64'd0);
      chk("flush_completed", {63'd0, bus32.completed}, 64'd0);
      chk("flush_result", {32'd0, bus32.result}, 64'd14);
      repeat (40) @(negedge clk);
      chk("flush_result_later", {32'd0, bus32.result}, 64'd14);
      run(0, 3'd0, 64'd3, 64'd4, 64'd12, 2, "mul_after_flush");

      run(1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'd1, 4, "mulhu64");
      run(1, 3'd4, 64'd100, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFDF, 65, "div64");

      // Reset in the middle of a 64-bit divide.
      drive(1, 1'b1, 3'd4, 64'd1000, 64'd7);
      @(negedge clk);
      drive(1, 1'b0, 3'd0, 64'd0, 64'd0);
      chk("rst_mid_busy_before", {63'd0, bus64.busy}, 64'd1);
      repeat (20) @(negedge clk);
      rstn64 = 1'b0;
      @(negedge clk);
      rstn64 = 1'b1;
      chk("rst_mid_busy", {63'd0, bus64.busy}, 64'd0);
      chk("rst_mid_completed", {63'd0, bus64.completed}, 64'd0);
      chk("rst_mid_result", bus64.result, 64'd0);
      repeat (70) @(negedge clk);
      chk("rst_mid_result_later", bus64.result, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for XLEN-bit operands.
- Replaces the single-cycle combinational multiply and divide path in the execute stage.
- Fixed-latency pipelined multiplier, iterative radix-2 divider, full RISC-V divide-by-zero and overflow semantics.
- Same enabled/completed handshake as the other execute units, plus busy and flush for the core's stall and trap logic.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_LATENCY, 2, clock edges from accept to completed for multiplies; legal range 1..4.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- enabled  in  1  start request; sampled only while busy=0.
- op  in  3  funct3 encoding: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- rs1  in  XLEN  operand 1.
- rs2  in  XLEN  operand 2.
- flush  in  1  abort the in-flight operation (trap or redirect).
- busy  out  1  operation in flight; new requests are ignored.
- completed  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  result; holds its value until the next completion.

Behaviour:
- Reset, when rstn=0 on an edge:
  - completed=0, busy=0, result=0.
  - FSM goes to IDLE; divider registers are cleared.
  - Any in-flight operation is dropped.
- Accept: on an edge with state=IDLE, enabled=1, flush=0.
  - op, rs1 and rs2 are latched.
  - busy=1 from that edge.
- FSM states:
  - IDLE: accepts requests.
  - MUL: latency counter running.
  - DIV: iteration counter running.
  - FIX: sign correction for the divider.
  - Transitions: IDLE->MUL for op 0-3; IDLE->DIV for op 4-7 normal case; IDLE->IDLE for divide special cases (completed next edge); MUL->IDLE when the counter reaches MUL_LATENCY; DIV->FIX after XLEN iterations; FIX->IDLE.
- Multiply:
  - Full 2*XLEN-bit product of sign- or zero-extended operands:
    - mul: both signed, low XLEN bits.
    - mulh: both signed, high XLEN bits.
    - mulhsu: rs1 signed, rs2 unsigned, high XLEN bits.
    - mulhu: both unsigned, high XLEN bits.
  - completed=1 exactly MUL_LATENCY edges after the accept edge.
- Divide, normal case:
  - Operate on magnitudes for signed ops.
  - Restoring algorithm, one quotient bit per cycle, XLEN cycles, then one FIX cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - completed=1 exactly XLEN+1 edges after the accept edge.
- Divide special cases, decided at accept; completed on the next edge:
  - rs2=0: div/divu give all ones; rem/remu give rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): div gives most-negative; rem gives 0.
- busy deasserts on the same edge that completed asserts.
  - The next request may be accepted on the following edge (back-to-back, one idle gap).
- completed is high for exactly one cycle; result is updated only on that edge.
- enabled while busy=1: ignored; no queueing.
- flush=1 on any edge:
  - State goes to IDLE, busy=0, completed=0.
  - result is unchanged.
  - flush takes priority over accept and over completion in the same cycle.
- Reset mid-operation behaves exactly like flush, and additionally clears result.

Test Plan:
- XLEN=32, MUL_LATENCY=2; mulh, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result 0x00000000; completed 2 edges after accept. Repeat with mulhu -> 0xFFFFFFFE. Repeat with mulhsu -> 0xFFFFFFFF. Repeat with mul -> 0x00000001.
- div, rs1=-7 (0xFFFFFFF9), rs2=2 -> result 0xFFFFFFFD, completed 33 edges after accept. Repeat with rem -> 0xFFFFFFFF. Repeat with divu -> 0x7FFFFFFC. Repeat with remu -> 1.
- Special cases:
  - divu 5/0 -> 0xFFFFFFFF after 1 edge.
  - remu 5/0 -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000.
  - rem of the same operands -> 0.
- Pulse enabled on cycles 5-20 during a div -> only one completion; result matches the first operands; busy high throughout.
- Assert flush 10 cycles into a div -> busy=0 next edge, no completed pulse, result keeps its previous value. A subsequent mul 3*4 -> 12.
- XLEN=64, MUL_LATENCY=4; mulhu 0xFFFFFFFFFFFFFFFF * 2 -> 1 after 4 edges. div 100/-3 -> -33 after 65 edges. Drop rstn mid-div -> completed=0, busy=0, result=0.
